// File: rtl/regfile_wr_arbiter.sv
// Arbitrates two writeback requesters onto the single register-file write port.
// Bypasses the staged write onto the read ports and diverts PC writes to a separate strobe.
module regfile_wr_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  // Handshake: a transfer happens in a cycle where valid & ready are both 1.
  // Ready is a pure function of the current valids and the priority pointer.
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wdata,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [15:0]       stall_cnt,
  output logic              dbg_ptr_b
);

  localparam logic [ADDR_W-1:0] PC_ADDR = '1;

  logic              ptr_b;
  logic              a_has_prio;
  logic              grant_a;
  logic              grant_b;
  logic              accept;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_is_pc;

  // Fixed-priority mode ignores the pointer entirely.
  assign a_has_prio = (PRIO_MODE == 1) || !ptr_b;

  always_comb begin
    grant_a = a_valid && (!b_valid || a_has_prio);
    grant_b = b_valid && !grant_a;
  end

  assign a_ready   = grant_a;
  assign b_ready   = grant_b;
  assign accept    = grant_a || grant_b;
  assign sel_addr  = grant_a ? a_addr : b_addr;
  assign sel_data  = grant_a ? a_data : b_data;
  assign sel_is_pc = (sel_addr == PC_ADDR);
  assign dbg_ptr_b = ptr_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_b     <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      pc_we     <= 1'b0;
      pc_wdata  <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && PRIO_MODE == 0) begin
        ptr_b <= grant_a;
      end
      rf_we <= accept && !sel_is_pc;
      pc_we <= accept && sel_is_pc;
      // Address/data hold their last value when nothing lands on the port.
      if (accept && !sel_is_pc) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
      if (accept && sel_is_pc) begin
        pc_wdata <= sel_data;
      end
      if (a_valid && b_valid && stall_cnt != 16'hFFFF) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end

  // rf_we is never set for the PC address, so PC reads fall through to the raw data.
  always_comb begin
    rd1 = rf_rd1;
    rd2 = rf_rd2;
    if (rf_we && rd_addr1 == rf_waddr && rd_addr1 != PC_ADDR) rd1 = rf_wdata;
    if (rf_we && rd_addr2 == rf_waddr && rd_addr2 != PC_ADDR) rd2 = rf_wdata;
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench: round-robin instance u0 and fixed-priority instance u1 share all inputs.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0]  a_addr = '0, b_addr = '0, rd_addr1 = '0, rd_addr2 = '0;
  logic [31:0] a_data = '0, b_data = '0, rf_rd1 = '0, rf_rd2 = '0;

  logic        a_ready0, b_ready0, rf_we0, pc_we0, ptr0;
  logic [3:0]  rf_waddr0;
  logic [31:0] rf_wdata0, pc_wdata0, rd1_0, rd2_0;
  logic [15:0] stall0;
  logic        a_ready1, b_ready1, rf_we1, pc_we1, ptr1;
  logic [3:0]  rf_waddr1;
  logic [31:0] rf_wdata1, pc_wdata1, rd1_1, rd2_1;
  logic [15:0] stall1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(4), .PRIO_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready0), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready0), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we0), .rf_waddr(rf_waddr0), .rf_wdata(rf_wdata0),
    .pc_we(pc_we0), .pc_wdata(pc_wdata0),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rd1(rd1_0), .rd2(rd2_0), .stall_cnt(stall0), .dbg_ptr_b(ptr0)
  );

  regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(4), .PRIO_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready1), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready1), .b_addr(b_addr), .b_data(b_data),
    .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
    .pc_we(pc_we1), .pc_wdata(pc_wdata1),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .rd1(rd1_1), .rd2(rd2_1), .stall_cnt(stall1), .dbg_ptr_b(ptr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    cyc();
    check("rst_rf_we", rf_we0, 0);
    check("rst_rf_waddr", rf_waddr0, 0);
    check("rst_rf_wdata", rf_wdata0, 0);
    check("rst_pc_we", pc_we0, 0);
    check("rst_pc_wdata", pc_wdata0, 0);
    check("rst_stall", stall0, 0);
    check("rst_ptr", ptr0, 0);
    check("idle_ready", {a_ready0, b_ready0}, 2'b00);
    rst_n = 1'b1;
    cyc();

    // Single A write, latency 1, one cycle wide
    a_valid = 1'b1; a_addr = 4'd3; a_data = 32'hDEAD_BEEF;
    #1 check("t1_a_ready", {a_ready0, b_ready0}, 2'b10);
    cyc();
    a_valid = 1'b0;
    check("t1_rf_we", rf_we0, 1);
    check("t1_rf_waddr", rf_waddr0, 3);
    check("t1_rf_wdata", rf_wdata0, 32'hDEAD_BEEF);
    check("t1_pc_we", pc_we0, 0);
    cyc();
    check("t1_rf_we_drop", rf_we0, 0);
    check("t1_waddr_hold", rf_waddr0, 3);
    check("t1_ptr_moved", ptr0, 1);

    // Continuous contention: u0 alternates A,B,A,B; u1 always grants A
    do_reset();
    a_valid = 1'b1; a_addr = 4'd1; a_data = 32'h11;
    b_valid = 1'b1; b_addr = 4'd2; b_data = 32'h22;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2_rr_ready", {a_ready0, b_ready0}, (k % 2 == 0) ? 2'b10 : 2'b01);
      check("t3_fp_ready", {a_ready1, b_ready1}, 2'b10);
      cyc();
      check("t2_rr_waddr", rf_waddr0, (k % 2 == 0) ? 1 : 2);
      check("t2_rr_wdata", rf_wdata0, (k % 2 == 0) ? 32'h11 : 32'h22);
      check("t2_rr_stall", stall0, k + 1);
      check("t3_fp_waddr", rf_waddr1, 1);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    cyc();
    check("t3_fp_stall", stall1, 4);
    check("t2_stall_hold", stall0, 4);

    // B write to PC diverts to pc_we; PC reads never bypass
    b_valid = 1'b1; b_addr = 4'd15; b_data = 32'h100;
    rd_addr1 = 4'd15; rf_rd1 = 32'hCAFE;
    #1 check("t4_b_ready", {a_ready0, b_ready0}, 2'b01);
    cyc();
    b_valid = 1'b0;
    check("t4_pc_we", pc_we0, 1);
    check("t4_pc_wdata", pc_wdata0, 32'h100);
    check("t4_rf_we", rf_we0, 0);
    #1 check("t4_rd1_pc", rd1_0, 32'hCAFE);
    cyc();
    check("t4_pc_we_drop", pc_we0, 0);

    // Bypass of the staged write on port 1, raw data on port 2
    a_valid = 1'b1; a_addr = 4'd5; a_data = 32'hABCD;
    cyc();
    a_valid = 1'b0;
    rd_addr1 = 4'd5; rd_addr2 = 4'd6; rf_rd1 = 32'h1111; rf_rd2 = 32'h2222;
    #1;
    check("t5_rd1_bypass", rd1_0, 32'hABCD);
    check("t5_rd2_raw", rd2_0, 32'h2222);
    rd_addr2 = 4'd5;
    #1 check("t5_rd2_bypass", rd2_0, 32'hABCD);
    cyc();
    check("t5_no_bypass_after", rd2_0, 32'h2222);
    check("t5_ptr_b", ptr0, 1);

    // Reset across an accepted transfer drops it and returns pointer to A
    a_valid = 1'b1; a_addr = 4'd7; a_data = 32'h77;
    b_valid = 1'b1; b_addr = 4'd8; b_data = 32'h88;
    #1 check("t6_b_wins_pre", {a_ready0, b_ready0}, 2'b01);
    rst_n = 1'b0;
    cyc();
    check("t6_rf_we", rf_we0, 0);
    check("t6_pc_we", pc_we0, 0);
    check("t6_stall", stall0, 0);
    check("t6_ptr", ptr0, 0);
    rst_n = 1'b1;
    #1 check("t6_first_grant_a", {a_ready0, b_ready0}, 2'b10);
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    check("t6_waddr", rf_waddr0, 7);
    check("t6_stall_after", stall0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port (write enable, write address, write data) between two writeback requesters.
  - Requester A: ALU/execute writeback.
  - Requester B: load/memory writeback.
- Registers the granted write into one output stage that drives the register file.
- Bypasses that in-flight write onto the two combinational read ports.
- Diverts writes to register 15 (PC) to a dedicated PC-write port.

Parameters:
- DATA_W, 32, data width of register file and requesters
- ADDR_W, 4, register address width (2**ADDR_W registers; address 2**ADDR_W-1 is PC)
- PRIO_MODE, 0, 0 = round-robin on contention; 1 = fixed priority, A always wins

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- a_valid  in  1  requester A has a write pending
- a_ready  out  1  A accepted this cycle when a_valid & a_ready
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid  in  1  requester B has a write pending
- b_ready  out  1  B accepted this cycle when b_valid & b_ready
- b_addr  in  ADDR_W  B destination register
- b_data  in  DATA_W  B write data
- rf_we  out  1  register-file write enable
- rf_waddr  out  ADDR_W  register-file write address
- rf_wdata  out  DATA_W  register-file write data
- pc_we  out  1  PC write strobe (write to register 15)
- pc_wdata  out  DATA_W  PC write data
- rd_addr1  in  ADDR_W  read port 1 address (also drives register file)
- rd_addr2  in  ADDR_W  read port 2 address
- rf_rd1  in  DATA_W  raw register-file read data 1
- rf_rd2  in  DATA_W  raw register-file read data 2
- rd1  out  DATA_W  bypassed read data 1
- rd2  out  DATA_W  bypassed read data 2
- stall_cnt  out  16  saturating count of requester-cycles lost to contention

Behaviour:
- Reset (async, rst_n=0):
  - rf_we=0, rf_waddr=0, rf_wdata=0, pc_we=0, pc_wdata=0, stall_cnt=0.
  - Priority pointer = A.
  - Reset mid-transfer drops the staged write; nothing is written.
- Ready (combinational from current valids and pointer):
  - Only A valid: a_ready=1.
  - Only B valid: b_ready=1.
  - Both valid: ready goes to the pointer's requester (PRIO_MODE=1: always A).
  - No valids: a_ready=b_ready=0.
  - At most one ready per cycle; ready never depends on the register file (no backpressure).
- Round-robin pointer (PRIO_MODE=0):
  - After any accepted transfer, the pointer moves to the other requester.
  - Unchanged when nothing is accepted.
- Output stage, latency 1:
  - A transfer accepted in cycle N appears on the stage in cycle N+1 for exactly one cycle.
  - Address != 15: rf_we=1, rf_waddr/rf_wdata = accepted addr/data, pc_we=0.
  - Address == 15: pc_we=1, pc_wdata=data, rf_we=0.
  - With no acceptance, rf_we=pc_we=0 next cycle; rf_waddr/rf_wdata hold their last value.
  - Throughput is one write per cycle.
- Bypass:
  - rd1 = rf_wdata if rf_we=1 and rd_addr1==rf_waddr, else rf_rd1. Same rule for rd2.
  - Reads of address 15 never bypass; pc_we does not affect rd1/rd2.
- Same destination from both requesters:
  - The loser waits.
  - Writes land in grant order; the later write wins in the register file.
- stall_cnt:
  - Increments by 1 each cycle both are valid (one requester loses).
  - Saturates at 16'hFFFF; cleared only by reset.
- Requesters must hold valid/addr/data stable until accepted. The block does not check this.

Test Plan:
1. Reset, then a_valid=1, a_addr=3, a_data=32'hDEAD_BEEF for one cycle → a_ready=1 that cycle. Next cycle rf_we=1, rf_waddr=3, rf_wdata=32'hDEAD_BEEF. Cycle after, rf_we=0.
2. PRIO_MODE=0, A and B both valid continuously (A addr 1 data 0x11, B addr 2 data 0x22) → grants A,B,A,B. rf_waddr sequence 1,2,1,2. stall_cnt increments by 1 per cycle.
3. PRIO_MODE=1, both valid for 4 cycles → a_ready=1 all 4 cycles, b_ready=0. stall_cnt=4.
4. b_valid with b_addr=15, b_data=0x100 → next cycle pc_we=1, pc_wdata=0x100, rf_we=0. rd_addr1=15 returns rf_rd1 unchanged.
5. Write addr 5 data 0xABCD accepted; next cycle rd_addr1=5, rd_addr2=6 → rd1=0xABCD (bypass), rd2=rf_rd2.
6. Transfer accepted, rst_n pulsed low before the next edge → rf_we=0, pc_we=0, stall_cnt=0, pointer=A; after release, the first contention grants A.
